// File: rtl/bridge_pkg.sv
// Shared types and default sizing for the trigger/a0 bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH      = 4;

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count.
module bridge_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       accept_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign pop_ok   = pop_i && !empty_o;
    // A full FIFO still takes a push when a pop frees the head slot this cycle.
    assign accept_o = push_i && (!full || pop_ok);
    assign count_d  = count_q + CW'(accept_o) - CW'(pop_ok);
    assign rdata_o  = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/trig_a0_bridge.sv
// Debounced push-button trigger pulse plus a0 change capture into a FIFO.
//   state       | meaning
//   IDLE        | button released and accepted as released
//   DEB_PRESS   | counting consecutive pressed samples
//   HELD        | press accepted, trigger already issued
//   DEB_RELEASE | counting consecutive released samples
module trig_a0_bridge
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_in,
    output logic                          trigger,
    input  logic [DATA_WIDTH-1:0]         a0,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync1_q, sync2_q;
    deb_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_inc;
    logic               trigger_q;
    logic [DATA_WIDTH-1:0] a0_prev_q;
    logic               overflow_q, overflow_d;
    logic               push_req, push_accept, fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    // The sample that enters a debounce state counts as the first stable one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q <= DEB_PRESS;
                        cnt_q   <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_q   <= HELD;
                        trigger_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_q <= DEB_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (sync2_q) begin
                        state_q <= HELD;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trigger = trigger_q;

    assign push_req   = (a0 != a0_prev_q);
    assign overflow_d = overflow_q | (push_req & ~push_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            a0_prev_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            a0_prev_q  <= a0;
            overflow_q <= overflow_d;
        end
    end

    bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_req),
        .pop_i    (out_ready),
        .wdata_i  (a0),
        .rdata_o  (out_data),
        .accept_o (push_accept),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_trig_a0_bridge.sv
// Directed and randomized checks of trig_a0_bridge against a behavioural model.
module tb_trig_a0_bridge;

    localparam int DW    = 32;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, btn_in, trigger, out_valid, out_ready, overflow;
    logic [DW-1:0] a0, out_data;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    trig_a0_bridge #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .trigger    (trigger),
        .a0         (a0),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: a two-sample delay line feeding a run-length debouncer, and a queue.
    bit            m_d1, m_d2, m_level, m_trig, m_ovf;
    int            m_run;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_prev;

    int cyc = 0;
    int trig_cnt = 0;
    int last_trig_cyc = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit samp, pop;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_trig = 0;
            m_q.delete();
            m_prev = '0;
            m_ovf = 0;
        end else begin
            samp = m_d2;
            m_d2 = m_d1;
            m_d1 = btn_in;
            m_trig = 0;
            if (samp != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = !m_level;
                    m_run = 0;
                    if (m_level) m_trig = 1;
                end
            end else begin
                m_run = 0;
            end
            pop = (m_q.size() > 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (a0 !== m_prev) begin
                if (m_q.size() < DEPTH) m_q.push_back(a0);
                else m_ovf = 1;
            end
            m_prev = a0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("trigger", trigger, m_trig);
        if (trigger) begin
            trig_cnt++;
            last_trig_cyc = cyc;
        end
        check("out_valid", out_valid, m_q.size() > 0);
        check("fifo_count", fifo_count, m_q.size());
        if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        rst = 1'b1; btn_in = 1'b0; a0 = '0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_count", fifo_count, 0);
        check("rst_valid", out_valid, 0);
        rst = 1'b0;
        repeat (3) step();

        // clean press, held 10 cycles
        trig_cnt = 0;
        t0 = cyc;
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        repeat (12) step();
        check("press_pulses", trig_cnt, 1);
        check("press_latency", last_trig_cyc - t0, 2 + DEB);

        // single-cycle bounce
        trig_cnt = 0;
        btn_in = 1'b1; step();
        btn_in = 1'b0; step();
        btn_in = 1'b1; step();
        btn_in = 1'b0; step();
        repeat (8) step();
        check("bounce_pulses", trig_cnt, 0);

        // change capture 0,5,5,7
        do_reset();
        a0 = 0; step();
        a0 = 5; step();
        a0 = 5; step();
        a0 = 7; step();
        check("cap_count", fifo_count, 2);
        check("cap_head", out_data, 5);
        out_ready = 1'b1;
        step();
        check("cap_pop1", out_data, 7);
        step();
        check("cap_empty", fifo_count, 0);

        // overflow on fifth distinct value
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a0 = 11 + i;
            step();
        end
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", out_data, 11 + i);
            step();
        end
        check("ovf_drained", fifo_count, 0);

        // full with simultaneous push and pop
        a0 = '0; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a0 = 21 + i;
            step();
        end
        check("fullpp_fill", fifo_count, 4);
        out_ready = 1'b1;
        a0 = 25;
        step();
        check("fullpp_count", fifo_count, 4);
        check("fullpp_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("fullpp_drain", out_data, 22 + i);
            step();
        end

        // reset during DEB_PRESS with a sample queued
        out_ready = 1'b0;
        trig_cnt = 0;
        a0 = 33; btn_in = 1'b1;
        repeat (4) step();
        rst = 1'b1; a0 = '0; btn_in = 1'b0;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("rstmid_pulses", trig_cnt, 0);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_ovf", overflow, 0);

        // nonzero a0 on first cycle after reset is a change
        rst = 1'b1; a0 = 77;
        step();
        rst = 1'b0;
        step();
        check("post_rst_count", fifo_count, 1);
        check("post_rst_data", out_data, 77);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_in = ~btn_in;
            if ($urandom_range(0, 2) == 0) a0 = DW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
